// File: rtl/handshake_frame_receiver.sv
// Two-phase req/ack word receiver that assembles MSB-first datagrams and commits them on frame_sync.
// Optional per-frame XOR check word is enabled by defining HFR_CHECKSUM_EN.
module handshake_frame_receiver #(
    parameter int DATA_W      = 6,
    parameter int MSG_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] din,
    input  logic              frame_sync,
    output logic              ack,
    output logic [MSG_W-1:0]  datagram,
    output logic              datagram_update,
    output logic              timeout_err,
    output logic              overrun,
    output logic              chk_err
);

    localparam int WORDS = (MSG_W + DATA_W - 1) / DATA_W;
`ifdef HFR_CHECKSUM_EN
    localparam int WORDS_TOT = WORDS + 1;
`else
    localparam int WORDS_TOT = WORDS;
`endif
    localparam int CNT_W   = $clog2(WORDS_TOT + 1);
    localparam int IDLE_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [PRIME_W-1:0]     prime_cnt_reg;
    logic                   primed_reg;
    logic                   req_prev_reg;
    logic                   ack_reg;
    logic [CNT_W-1:0]       word_cnt_reg;
    logic [IDLE_W-1:0]      idle_reg;
    logic [MSG_W-1:0]       pending_reg;
    logic                   pending_valid_reg;
    logic [MSG_W-1:0]       datagram_reg;
    logic                   datagram_update_reg;
    logic                   timeout_err_reg;
    logic                   overrun_reg;

    logic                   req_s;
    logic                   capture;
    logic                   last_word;
    logic                   commit;
    logic                   timeout_hit;
    logic                   frame_done;
    logic [MSG_W-1:0]       frame_data;
    logic                   chk_ok;

    always_comb begin
        req_s       = sync_reg[SYNC_STAGES-1];
        capture     = primed_reg && (req_s != req_prev_reg);
        last_word   = (word_cnt_reg == CNT_W'(WORDS_TOT - 1));
        commit      = frame_sync && pending_valid_reg;
        timeout_hit = (TIMEOUT > 0) && (word_cnt_reg != '0) && (idle_reg == IDLE_W'(TIMEOUT));
        frame_done  = capture && last_word && chk_ok;
    end

`ifdef HFR_CHECKSUM_EN
    // Payload is complete one word before the check word, so pending takes sr as it stood then.
    logic [MSG_W-1:0]  sr_reg;
    logic [MSG_W-1:0]  sr_next;
    logic [DATA_W-1:0] xor_reg;
    logic [DATA_W-1:0] xor_next;
    logic              chk_err_reg;

    always_comb begin
        sr_next    = {sr_reg[MSG_W-DATA_W-1:0], din};
        frame_data = sr_reg;
        xor_next   = (word_cnt_reg == '0) ? din : (xor_reg ^ din);
        chk_ok     = (din == xor_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_reg      <= '0;
            xor_reg     <= '0;
            chk_err_reg <= 1'b0;
        end else begin
            chk_err_reg <= capture && last_word && !chk_ok;
            if (capture) begin
                sr_reg  <= sr_next;
                xor_reg <= xor_next;
            end
        end
    end

    assign chk_err = chk_err_reg;
`else
    // Only the low MSG_W-DATA_W bits are kept; padding falls off the top on the last shift.
    logic [MSG_W-DATA_W-1:0] sr_reg;

    always_comb begin
        frame_data = {sr_reg, din};
        chk_ok     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_reg <= '0;
        end else if (capture) begin
            sr_reg <= frame_data[MSG_W-DATA_W-1:0];
        end
    end

    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg            <= '0;
            prime_cnt_reg       <= '0;
            primed_reg          <= 1'b0;
            req_prev_reg        <= 1'b0;
            ack_reg             <= 1'b0;
            word_cnt_reg        <= '0;
            idle_reg            <= '0;
            pending_reg         <= '0;
            pending_valid_reg   <= 1'b0;
            datagram_reg        <= '0;
            datagram_update_reg <= 1'b0;
            timeout_err_reg     <= 1'b0;
            overrun_reg         <= 1'b0;
        end else begin
            sync_reg            <= {sync_reg[SYNC_STAGES-2:0], req};
            datagram_update_reg <= 1'b0;
            timeout_err_reg     <= 1'b0;
            overrun_reg         <= 1'b0;

            // The chain restarts from 0 after reset, so req_prev tracks req_s until the chain has filled;
            // a req held high through reset is then absorbed as the reference phase.
            if (!primed_reg) begin
                req_prev_reg <= req_s;
                if (prime_cnt_reg == PRIME_W'(SYNC_STAGES)) begin
                    primed_reg <= 1'b1;
                end else begin
                    prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
                end
            end

            if (capture) begin
                req_prev_reg <= req_s;
                ack_reg      <= req_s;
                idle_reg     <= '0;
                word_cnt_reg <= last_word ? '0 : word_cnt_reg + CNT_W'(1);
            end else if (timeout_hit) begin
                word_cnt_reg    <= '0;
                idle_reg        <= '0;
                timeout_err_reg <= 1'b1;
            end else if (word_cnt_reg != '0) begin
                idle_reg <= idle_reg + IDLE_W'(1);
            end else begin
                idle_reg <= '0;
            end

            if (commit) begin
                datagram_reg        <= pending_reg;
                datagram_update_reg <= 1'b1;
            end

            // A same-cycle commit has already taken the old pending, so that case is not an overrun.
            if (frame_done) begin
                pending_reg       <= frame_data;
                pending_valid_reg <= 1'b1;
                overrun_reg       <= pending_valid_reg && !commit;
            end else if (commit) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign ack             = ack_reg;
    assign datagram        = datagram_reg;
    assign datagram_update = datagram_update_reg;
    assign timeout_err     = timeout_err_reg;
    assign overrun         = overrun_reg;

endmodule

// File: tb/tb_handshake_frame_receiver.sv
// Directed bench for handshake_frame_receiver: expected output events go into a queue that a monitor drains.
`timescale 1ns/1ps
module tb_handshake_frame_receiver;

    localparam int DATA_W = 6;
    localparam int MSG_W  = 16;
    localparam int EV_UPD = 0;
    localparam int EV_TO  = 1;
    localparam int EV_OVR = 2;
    localparam int EV_CHK = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              frame_sync = 1'b0;
    logic              ack;
    logic [MSG_W-1:0]  datagram;
    logic              datagram_update;
    logic              timeout_err;
    logic              overrun;
    logic              chk_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        logic [15:0] data;
    } evt_t;

    evt_t exp_q[$];

    handshake_frame_receiver #(
        .DATA_W(DATA_W),
        .MSG_W(MSG_W),
        .SYNC_STAGES(2),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .din(din),
        .frame_sync(frame_sync),
        .ack(ack),
        .datagram(datagram),
        .datagram_update(datagram_update),
        .timeout_err(timeout_err),
        .overrun(overrun),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            EV_UPD:  return "update";
            EV_TO:   return "timeout";
            EV_OVR:  return "overrun";
            default: return "chk_err";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end else begin
            $display("check %s ok: 0x%0h", name, act);
        end
    endtask

    task automatic expect_evt(input int kind, input logic [15:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic on_event(input int kind, input logic [15:0] data);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s data=0x%04h expected no event", kname(kind), data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_UPD && e.data !== data)) begin
                bad++;
                $display("FAIL event: got %s data=0x%04h expected %s data=0x%04h",
                         kname(kind), data, kname(e.kind), e.data);
            end else begin
                $display("event %s data=0x%04h as expected", kname(kind), data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (datagram_update) on_event(EV_UPD, datagram);
            if (timeout_err)     on_event(EV_TO, datagram);
            if (overrun)         on_event(EV_OVR, datagram);
            if (chk_err)         on_event(EV_CHK, datagram);
        end
    end

    // Toggles req with a new word and optionally checks the 3-clock ack latency;
    // sync_at_cap raises frame_sync exactly in the cycle the word is captured.
    task automatic send_word(input logic [DATA_W-1:0] w, input bit chk_ack, input bit sync_at_cap);
        int n = 0;
        bit done = 1'b0;
        int limit = chk_ack ? 12 : 6;
        @(negedge clk);
        din = w;
        req = ~req;
        while (!done && n < limit) begin
            @(posedge clk);
            n++;
            #1;
            if (sync_at_cap) frame_sync = (n == 2);
            if (chk_ack && ack == req) done = 1'b1;
        end
        frame_sync = 1'b0;
        if (chk_ack) begin
            total++;
            if (!done || n != 3) begin
                bad++;
                $display("FAIL ack_latency: got %0d clks (ack seen=%0d) expected 3 clks", n, done);
            end else begin
                $display("word 0x%02h sent, ack after %0d clks", w, n);
            end
        end else begin
            $display("word 0x%02h sent without ack check", w);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                              input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] c,
                              input bit sync_last);
        $display("frame %02h %02h %02h check %02h", w0, w1, w2, c);
        send_word(w0, 1'b1, 1'b0);
        send_word(w1, 1'b1, 1'b0);
`ifdef HFR_CHECKSUM_EN
        send_word(w2, 1'b1, 1'b0);
        send_word(c, 1'b1, sync_last);
`else
        send_word(w2, 1'b1, sync_last);
`endif
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        // Reset with req held high; the receiver must not see this as a toggle.
        rst = 1'b0;
        req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_datagram", 32'(datagram), 32'd0);
        check("reset_update", 32'(datagram_update), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_chk_err", 32'(chk_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("primed_ack", 32'(ack), 32'd0);

        // First toggle (1->0) is word 0; ack stays at 0 because it follows req_s.
        send_word(6'h02, 1'b0, 1'b0);
        check("word0_ack", 32'(ack), 32'd0);
        send_word(6'h3F, 1'b1, 1'b0);
`ifdef HFR_CHECKSUM_EN
        send_word(6'h15, 1'b1, 1'b0);
        send_word(6'h28, 1'b1, 1'b0);
`else
        send_word(6'h15, 1'b1, 1'b0);
`endif
        check("held_before_commit", 32'(datagram), 32'd0);
        expect_evt(EV_UPD, 16'h2FD5);
        pulse_sync();
        check("datagram_first", 32'(datagram), 32'h2FD5);

        // Two frames without commit: overrun, latest wins.
        send_frame(6'h02, 6'h3F, 6'h15, 6'h28, 1'b0);
        expect_evt(EV_OVR, 16'h0);
        send_frame(6'h01, 6'h08, 6'h34, 6'h3D, 1'b0);
        expect_evt(EV_UPD, 16'h1234);
        pulse_sync();

        // Partial frame times out, then a fresh frame is assembled cleanly.
        expect_evt(EV_TO, 16'h0);
        send_word(6'h2A, 1'b1, 1'b0);
        repeat (25) @(posedge clk);
        send_frame(6'h0A, 6'h2F, 6'h0D, 6'h28, 1'b0);
        #1;
        check("datagram_unchanged", 32'(datagram), 32'h1234);
        expect_evt(EV_UPD, 16'hABCD);
        pulse_sync();

        // Commit in the same cycle as completion: old pending out, new pending kept, no overrun.
        send_frame(6'h02, 6'h3F, 6'h15, 6'h28, 1'b0);
        expect_evt(EV_UPD, 16'h2FD5);
        send_frame(6'h01, 6'h08, 6'h34, 6'h3D, 1'b1);
        repeat (3) @(posedge clk);
        expect_evt(EV_UPD, 16'h1234);
        pulse_sync();
        pulse_sync();
        #1;
        check("datagram_after_empty_sync", 32'(datagram), 32'h1234);

`ifdef HFR_CHECKSUM_EN
        expect_evt(EV_CHK, 16'h0);
        send_frame(6'h02, 6'h3F, 6'h15, 6'h29, 1'b0);
        pulse_sync();
        #1;
        check("chk_bad_no_commit", 32'(datagram), 32'h1234);
`endif

        repeat (30) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
